instr_fetch_unit: RTL and testbench

Instruction-fetch stage of the single-cycle RV32 core: holds the program counter, issues one read per instruction to the instruction memory over a request/valid interface, and presents the fetched word to the decode/control stage. It sits directly upstream of the control unit and datapath. It consumes the control unit's `PC_Src` and the sign-extended branch immediate to choose the next PC, and adds stall tolerance for instruction memories with variable latency.

---
 rtl/instr_fetch_unit.sv | 99 +++++++++
 tb/tb_instr_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: holds the PC, issues one imem read per instruction, presents the word to decode.
// Latency: request in FETCH, word valid one cycle after imem_rvalid; L+2 cycles per instruction minimum.
// Backpressure: the presented word, PC and valid hold in VALID until instr_ready; one read in flight max.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_Src,
    input  logic [31:0] Imm_Ext,
    input  logic        instr_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PC_Plus4,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        vld_q, vld_d;
    logic        err_q, err_d;
    logic [31:0] next_pc;

    assign next_pc = PC_Src ? (pc_q + Imm_Ext) : (pc_q + 32'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        err_d   = err_q;
        case (state_q)
            FETCH: state_d = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    vld_d   = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    vld_d = 1'b0;
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        instr_d = NOP_INSTR;
                        state_d = FETCH;
                    end else begin
                        // PC keeps the faulting instruction's address for debug
                        err_d   = 1'b1;
                        state_d = HALT;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Request is decoded from state but suppressed while reset is held
    assign imem_req     = (state_q == FETCH) && !rst;
    assign imem_addr    = pc_q;
    assign PC           = pc_q;
    assign PC_Plus4     = pc_q + 32'd4;
    assign Instr        = instr_q;
    assign instr_valid  = vld_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized checks of instr_fetch_unit against a PC-sequence reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_Src;
    logic [31:0] Imm_Ext;
    logic        instr_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PC_Plus4;
    logic        misalign_err;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_pc;
    bit          m_halted;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .PC_Src(PC_Src), .Imm_Ext(Imm_Ext),
        .instr_ready(instr_ready), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .Instr(Instr),
        .instr_valid(instr_valid), .PC(PC), .PC_Plus4(PC_Plus4),
        .misalign_err(misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full instruction: request check, memory response after lat cycles,
    // stall cycles with ready low, then handshake with the given branch inputs.
    task automatic do_instr(input int lat, input int stall, input bit src,
                            input logic [31:0] imm, input logic [31:0] data,
                            input bit stray, input bit stale);
        logic [31:0] nxt;
        chk("req_now", imem_req, 1'b1);
        chk("req_addr", imem_addr, m_pc);
        chk("pc_plus4", PC_Plus4, m_pc + 32'd4);
        chk("valid_in_fetch", instr_valid, 1'b0);
        imem_rvalid = stale;
        imem_rdata  = ~data;
        tick();
        imem_rvalid = 1'b0;
        chk("valid_in_wait", instr_valid, 1'b0);
        for (int k = 1; k < lat; k++) begin
            tick();
            chk("no_req_wait", imem_req, 1'b0);
            chk("valid_wait", instr_valid, 1'b0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        chk("valid_up", instr_valid, 1'b1);
        chk("instr_word", Instr, data);
        chk("pc_held", PC, m_pc);
        chk("no_req_valid", imem_req, 1'b0);
        for (int s = 0; s < stall; s++) begin
            instr_ready = 1'b0;
            imem_rvalid = stray && (s == 1);
            imem_rdata  = ~data;
            PC_Src      = $urandom;
            Imm_Ext     = $urandom;
            tick();
            imem_rvalid = 1'b0;
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_instr", Instr, data);
            chk("stall_pc", PC, m_pc);
            chk("stall_no_req", imem_req, 1'b0);
        end
        instr_ready = 1'b1;
        PC_Src      = src;
        Imm_Ext     = imm;
        tick();
        instr_ready = 1'b0;
        PC_Src      = $urandom;
        Imm_Ext     = $urandom;
        nxt = src ? m_pc + imm : m_pc + 32'd4;
        chk("valid_cleared", instr_valid, 1'b0);
        if (nxt[1:0] != 2'b00) begin
            m_halted = 1'b1;
            chk("err_set", misalign_err, 1'b1);
            chk("halt_pc", PC, m_pc);
            for (int h = 0; h < 6; h++) begin
                imem_rvalid = 1'b1;
                instr_ready = 1'b1;
                chk("halt_no_req", imem_req, 1'b0);
                tick();
                chk("halt_valid", instr_valid, 1'b0);
                chk("halt_err", misalign_err, 1'b1);
                chk("halt_pc_stable", PC, m_pc);
            end
            imem_rvalid = 1'b0;
            instr_ready = 1'b0;
        end else begin
            m_pc = nxt;
            chk("nop_after", Instr, NOP);
            chk("no_err", misalign_err, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_pc", PC, RST_PC);
        chk("rst_instr", Instr, NOP);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_err", misalign_err, 1'b0);
        tick();
        chk("rst_req_hold", imem_req, 1'b0);
        rst = 1'b0;
        m_pc = RST_PC;
        m_halted = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; PC_Src = 1'b0; Imm_Ext = '0; instr_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        m_pc = RST_PC; m_halted = 1'b0;
        tick();
        do_reset();

        // First fetch, then sequential stream 0,4,8,12 with ready high
        do_instr(1, 0, 1'b0, 32'h0, 32'h0050_0093, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            do_instr(1, 0, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
        chk("seq_end_pc", m_pc, 32'd16);

        // Taken branches
        do_instr(1, 0, 1'b1, 32'hFFFF_FFF8, $urandom, 1'b0, 1'b0);
        do_instr(1, 0, 1'b1, 32'hFFFF_FFF8, $urandom, 1'b0, 1'b0);
        do_instr(1, 0, 1'b0, 32'h0, $urandom, 1'b0, 1'b0);
        do_instr(1, 0, 1'b0, 32'h0, $urandom, 1'b0, 1'b0);
        do_instr(2, 1, 1'b1, 32'd16, $urandom, 1'b0, 1'b1);
        chk("branch_fwd_pc", imem_addr, 32'd24);

        // Long latency, stalled consumer, stray response during VALID
        do_instr(5, 4, 1'b0, 32'h0, $urandom, 1'b1, 1'b0);

        // Randomized aligned stream
        for (int i = 0; i < 10; i++) begin
            int off;
            off = $urandom_range(0, 16);
            do_instr($urandom_range(1, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     32'((off - 8) * 4), $urandom, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        // Jump to the top of the address space and wrap sequentially to 0
        do_instr(1, 0, 1'b1, 32'hFFFF_FFFC - m_pc, $urandom, 1'b0, 1'b0);
        chk("top_pc", PC, 32'hFFFF_FFFC);
        do_instr(1, 0, 1'b0, 32'h0, $urandom, 1'b0, 1'b0);
        chk("wrap_pc", imem_addr, 32'h0);

        // Misaligned branch target halts the unit
        do_instr(1, 0, 1'b0, 32'h0, $urandom, 1'b0, 1'b0);
        do_instr(1, 0, 1'b1, 32'd2, $urandom, 1'b0, 1'b0);
        chk("halted_model", 32'(m_halted), 32'd1);
        do_reset();
        chk("err_cleared", misalign_err, 1'b0);

        // Reset while a read is outstanding; the late response must be ignored
        do_instr(1, 0, 1'b0, 32'h0, $urandom, 1'b0, 1'b0);
        chk("pre_abort_addr", imem_addr, 32'd4);
        tick();
        chk("abort_in_wait", imem_req, 1'b0);
        do_reset();
        do_instr(3, 2, 1'b0, 32'h0, $urandom, 1'b0, 1'b1);
        do_instr(1, 0, 1'b0, 32'h0, $urandom, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
